// File: rtl/frame_streamer.sv
// frame_streamer: frame buffer loaded over a write port, replayed in raster
// order as a channel-parallel pixel stream with frame_start/frame_done.
//
// Ports:
//   clk, rst (sync, active-high)
//   wr_en/wr_addr/wr_data : frame buffer write port (ignored while busy)
//   start                 : begin one frame (sampled in IDLE only)
//   stall                 : hold pixel issue while high
//   pixel_out/pixel_valid : registered pixel word and its valid
//   frame_start           : with pixel 0 only
//   frame_done            : one-cycle pulse after the last pixel
//   busy                  : start accepted until frame_done
// Optional: define FRAME_STREAMER_COORD_EN to add col_out/row_out, the
// coordinates of the pixel on pixel_out.
module frame_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_CHANNEL = 3,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int LINE_GAP   = 0,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [IN_CHANNEL*DATA_WIDTH-1:0] wr_data,
    input  logic                             start,
    input  logic                             stall,
    output logic [IN_CHANNEL*DATA_WIDTH-1:0] pixel_out,
    output logic                             pixel_valid,
    output logic                             frame_start,
    output logic                             frame_done,
    output logic                             busy
`ifdef FRAME_STREAMER_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]     col_out,
    output logic [$clog2(IMG_HEIGHT)-1:0]    row_out
`endif
);

    localparam int PW   = IN_CHANNEL * DATA_WIDTH;
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int GW   = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [ADDR_WIDTH:0] NPIX_A = (ADDR_WIDTH+1)'(NPIX);
    localparam logic [CW-1:0]       COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]       ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [GW-1:0]       GAP_LAST = GW'(LINE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        FLUSH
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [PW-1:0]         pixel_out_q;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_done_q, frame_done_d;
    logic                  issue;
    logic                  wr_ok;

    logic [PW-1:0] frame_mem [NPIX];

    // Buffer is only writable between frames, so a write never races a read.
    assign wr_ok = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < NPIX_A);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            frame_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        addr_d        = addr_q;
        gap_d         = gap_q;
        issue         = 1'b0;
        frame_done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            STREAM: begin
                if (!stall) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (row_q == ROW_LAST) begin
                            state_d = FLUSH;
                            row_d   = '0;
                            addr_d  = '0;
                        end else if (LINE_GAP > 0) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = STREAM;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            FLUSH: begin
                // Last pixel is on the output now; close the frame.
                state_d      = IDLE;
                frame_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        pixel_valid_d = issue;
        frame_start_d = issue && (addr_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            gap_q         <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            addr_q        <= addr_d;
            gap_q         <= gap_d;
            pixel_valid_q <= pixel_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            // Synchronous buffer read doubles as the output register.
            if (issue) begin
                pixel_out_q <= frame_mem[addr_q];
            end
        end
    end

    assign pixel_out   = pixel_out_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q != IDLE);

`ifdef FRAME_STREAMER_COORD_EN
    logic [CW-1:0] col_out_q;
    logic [RW-1:0] row_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_out_q <= '0;
            row_out_q <= '0;
        end else if (issue) begin
            col_out_q <= col_q;
            row_out_q <= row_q;
        end
    end

    assign col_out = col_out_q;
    assign row_out = row_out_q;
`endif

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: table-driven checks of frame_streamer on a 4x3 image,
// with one back-to-back instance and one LINE_GAP=2 instance.
module tb_frame_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = 4;
    localparam int PW = 24;
    localparam int NV = 40;
`ifdef FRAME_STREAMER_COORD_EN
    localparam bit COORD = 1'b1;
`else
    localparam bit COORD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, wr_en, start, stall;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic [PW-1:0] pix0, pix2;
    logic          v0, fs0, fd0, b0;
    logic          v2, fs2, fd2, b2;
`ifdef FRAME_STREAMER_COORD_EN
    logic [1:0]    col0, row0, col2, row2;
`endif

    always #5 clk = ~clk;

    frame_streamer #(
        .DATA_WIDTH(8), .IN_CHANNEL(3), .IMG_WIDTH(W),
        .IMG_HEIGHT(H), .LINE_GAP(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .stall(stall),
        .pixel_out(pix0), .pixel_valid(v0), .frame_start(fs0),
        .frame_done(fd0), .busy(b0)
`ifdef FRAME_STREAMER_COORD_EN
        , .col_out(col0), .row_out(row0)
`endif
    );

    frame_streamer #(
        .DATA_WIDTH(8), .IN_CHANNEL(3), .IMG_WIDTH(W),
        .IMG_HEIGHT(H), .LINE_GAP(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .stall(stall),
        .pixel_out(pix2), .pixel_valid(v2), .frame_start(fs2),
        .frame_done(fd2), .busy(b2)
`ifdef FRAME_STREAMER_COORD_EN
        , .col_out(col2), .row_out(row2)
`endif
    );

    typedef struct packed {
        logic          v;
        logic          fs;
        logic          fd;
        logic          b;
        logic [1:0]    row;
        logic [1:0]    col;
        logic [PW-1:0] pix;
    } obs_t;

    typedef struct {
        logic          start;
        logic          stall;
        logic          wr_en;
        logic [AW-1:0] wa;
        logic [PW-1:0] wd;
        logic          chk2;
        obs_t          e0;
        obs_t          e2;
    } vec_t;

    vec_t          tv [NV];
    int            nv;
    int            pos [N];
    logic [PW-1:0] mdl [N];
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [PW-1:0] word(input int i);
        return {8'(i + 2), 8'(i + 1), 8'(i)};
    endfunction

    function automatic obs_t get0();
        obs_t o = '0;
        o.v = v0; o.fs = fs0; o.fd = fd0; o.b = b0; o.pix = pix0;
`ifdef FRAME_STREAMER_COORD_EN
        o.row = row0; o.col = col0;
`endif
        return o;
    endfunction

    function automatic obs_t get2();
        obs_t o = '0;
        o.v = v2; o.fs = fs2; o.fd = fd2; o.b = b2; o.pix = pix2;
`ifdef FRAME_STREAMER_COORD_EN
        o.row = row2; o.col = col2;
`endif
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        obs_t a = act;
        obs_t e = exp;
        // Coordinates are only defined alongside a valid pixel.
        if (!COORD || !e.v) begin
            a.row = '0; a.col = '0;
            e.row = '0; e.col = '0;
        end
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got v=%b fs=%b fd=%b busy=%b r=%0d c=%0d pix=%h, want v=%b fs=%b fd=%b busy=%b r=%0d c=%0d pix=%h",
                     name, a.v, a.fs, a.fd, a.b, a.row, a.col, a.pix,
                     e.v, e.fs, e.fd, e.b, e.row, e.col, e.pix);
        end
    endtask

    task automatic clear_table(input int n);
        nv = n;
        for (int j = 0; j < NV; j++) begin
            tv[j].start = 1'b0; tv[j].stall = 1'b0;
            tv[j].wr_en = 1'b0; tv[j].wa = '0; tv[j].wd = '0;
            tv[j].chk2  = 1'b0; tv[j].e0 = '0; tv[j].e2 = '0;
        end
    endtask

    // Expected outputs from vector base on: pos[i] is the offset at which
    // word i is valid, fd_j the offset of frame_done.
    task automatic fill(input bit d2, input int base, input int fd_j,
                        input logic [PW-1:0] init);
        logic [PW-1:0] last = init;
        for (int j = base; j < nv; j++) begin
            obs_t e = '0;
            int   r = j - base;
            e.b  = (r < fd_j);
            e.fd = (r == fd_j);
            for (int i = 0; i < N; i++) begin
                if (pos[i] == r) begin
                    e.v   = 1'b1;
                    e.fs  = (i == 0);
                    last  = mdl[i];
                    e.row = 2'(i / W);
                    e.col = 2'(i % W);
                end
            end
            e.pix = last;
            if (d2) tv[j].e2 = e;
            else    tv[j].e0 = e;
        end
    endtask

    task automatic pos_plain();
        for (int i = 0; i < N; i++) pos[i] = i + 1;
    endtask

    task automatic pos_gap2();
        for (int i = 0; i < N; i++) pos[i] = i + 1 + 2 * (i / W);
    endtask

    task automatic apply(input string tag);
        for (int j = 0; j < nv; j++) begin
            start   = tv[j].start;
            stall   = tv[j].stall;
            wr_en   = tv[j].wr_en;
            wr_addr = tv[j].wa;
            wr_data = tv[j].wd;
            step();
            check($sformatf("%s0[%0d]", tag, j), get0(), tv[j].e0);
            if (tv[j].chk2)
                check($sformatf("%s2[%0d]", tag, j), get2(), tv[j].e2);
        end
        start = 1'b0; stall = 1'b0; wr_en = 1'b0;
        repeat (4) step();
    endtask

    task automatic build_plain_frame(input logic [PW-1:0] i0,
                                     input logic [PW-1:0] i2);
        clear_table(20);
        tv[0].start = 1'b1;
        for (int j = 0; j < nv; j++) tv[j].chk2 = 1'b1;
        pos_plain();
        fill(1'b0, 0, 13, i0);
        pos_gap2();
        fill(1'b1, 0, 17, i2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int   seen;
        int   fd_hits;
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; stall = 1'b0;
        wr_addr = '0; wr_data = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset0", get0(), '0);
        check("reset2", get2(), '0);

        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = word(i);
            mdl[i] = word(i);
            step();
        end
        wr_en = 1'b0;
        step();

        // Back-to-back frame and a LINE_GAP=2 frame side by side.
        build_plain_frame('0, '0);
        apply("gap");

        // Stall for 3 cycles from the cycle word 5 is on the output.
        clear_table(24);
        tv[0].start = 1'b1;
        for (int j = 7; j <= 9; j++) tv[j].stall = 1'b1;
        for (int i = 0; i < N; i++) pos[i] = (i <= 5) ? i + 1 : i + 4;
        fill(1'b0, 0, 16, mdl[11]);
        apply("stall");

        // Restart and write while busy are ignored; restart in the
        // frame_done cycle is accepted.
        clear_table(30);
        tv[0].start = 1'b1;
        tv[5].start = 1'b1;
        tv[6].wr_en = 1'b1; tv[6].wa = 4'd10; tv[6].wd = 24'hABCDEF;
        tv[14].start = 1'b1;
        pos_plain();
        fill(1'b0, 0, 13, mdl[11]);
        fill(1'b0, 14, 13, mdl[11]);
        apply("busy");

        // Reset while word 6 is on the output.
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            step();
            if (v0 && pix0 === mdl[6]) seen = 1;
        end
        n_cmp++;
        if (seen == 0) begin
            n_bad++;
            $display("FAIL rst_wait: got no word 6 within 20 cycles, want word 6");
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid0", get0(), '0);
        check("rst_mid2", get2(), '0);
        fd_hits = 0;
        repeat (6) begin
            step();
            if (fd0 || fd2 || b0 || b2 || v0 || v2) fd_hits++;
        end
        n_cmp++;
        if (fd_hits != 0) begin
            n_bad++;
            $display("FAIL rst_quiet: got %0d active cycles, want 0", fd_hits);
        end
        build_plain_frame('0, '0);
        apply("rst");

        // Out-of-range writes, then start together with a write to word 2.
        for (int a = N; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = 24'hFFFFFF;
            step();
        end
        wr_en = 1'b0;
        step();
        mdl[2] = 24'h123456;
        build_plain_frame(mdl[11], mdl[11]);
        tv[0].wr_en = 1'b1; tv[0].wa = 4'd2; tv[0].wd = 24'h123456;
        apply("wrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
Pixel-stream source for the conv layer. Holds one multi-channel image in an internal frame buffer that is loaded over a simple write port. On a start pulse it replays the image in raster order on the conv input interface: channel-parallel pixel bus, pixel_valid, and a one-cycle frame_start on the first pixel. Used in benches and as the front end that feeds conv from a host-loaded buffer.

Parameters:
DATA_WIDTH, 8, bits per channel sample
IN_CHANNEL, 3, channels packed per pixel word
IMG_WIDTH, 32, pixels per row
IMG_HEIGHT, 32, rows per frame
LINE_GAP, 0, idle issue cycles inserted between rows (0 = back-to-back)
ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), frame buffer address width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  frame buffer write strobe
wr_addr  input  ADDR_WIDTH  write address, raster index row*IMG_WIDTH+col
wr_data  input  IN_CHANNEL*DATA_WIDTH  pixel word; channel i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
start  input  1  begin streaming one frame (sampled in IDLE only)
stall  input  1  pause pixel issue while high
pixel_out  output  IN_CHANNEL*DATA_WIDTH  pixel word to conv pixel_in
pixel_valid  output  1  pixel_out valid this cycle
frame_start  output  1  high with pixel_valid on pixel 0 only
frame_done  output  1  one-cycle pulse after the last pixel
busy  output  1  high from start acceptance until frame_done

Behaviour:
- Reset: state IDLE; pixel_out=0, pixel_valid=0, frame_start=0, frame_done=0, busy=0; counters cleared. Frame buffer contents are NOT cleared.
- Frame buffer: IMG_WIDTH*IMG_HEIGHT words, synchronous write and synchronous read with 1-cycle latency. Writes with wr_addr >= IMG_WIDTH*IMG_HEIGHT are dropped. Writes while busy=1 are dropped.
- States: IDLE, STREAM, GAP, FLUSH.
- IDLE: on start=1 at edge k, go to STREAM and set busy=1 from k+1.
- STREAM: each cycle with stall=0 issues a read of the current (row,col) and advances col. At col wrap (col==IMG_WIDTH-1):
  - last row: go to FLUSH.
  - else if LINE_GAP>0: go to GAP.
  - else: continue in STREAM.
  stall=1 issues nothing and holds the counters.
- GAP: counts LINE_GAP cycles, then returns to STREAM. stall has no effect in GAP.
- FLUSH: the last pixel emerges; next cycle frame_done=1, busy=0, state IDLE.
- Output register: a read issued at edge n gives pixel_valid=1 with its data at edge n+1. With start at edge k, pixel 0 is valid at edge k+2 with frame_start=1. pixel_out holds its last value when pixel_valid=0.
- Stall: asserting stall drops pixel_valid one cycle later. The pixel already in flight is still emitted; no pixel is dropped or duplicated.
- Frame length with no stall: IMG_WIDTH*IMG_HEIGHT valid cycles plus (IMG_HEIGHT-1)*LINE_GAP idle cycles.
- start while busy is ignored. start in the frame_done cycle is accepted (state is IDLE).
- Simultaneous start and wr_en in IDLE: the write completes, and the stream reads the new data if its address is not yet read.
- rst mid-frame: immediate return to reset values; no frame_done is generated.

Optional Feature:
FRAME_STREAMER_COORD_EN:
- Defined: adds outputs col_out [$clog2(IMG_WIDTH)-1:0] and row_out [$clog2(IMG_HEIGHT)-1:0]. They carry the coordinates of the pixel on pixel_out, are aligned with pixel_valid, and reset to 0.
- Undefined: these ports and their pipeline registers do not exist. All other behaviour is identical.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3, IN_CHANNEL=3, DATA_WIDTH=8):
- Load word i = {i+2, i+1, i} for i=0..11, then pulse start, LINE_GAP=0 -> pixel_valid for 12 consecutive cycles starting 2 cycles after start; words 0..11 in order; frame_start only on word 0; frame_done 1 cycle after word 11; busy low at the same edge.
- LINE_GAP=2, same image -> exactly 2 idle cycles after words 3 and 7; total span 16 cycles; none after word 11.
- stall high for 3 cycles starting at the issue cycle of word 5 -> word 5 still emitted, then 3 invalid cycles, then word 6; 12 words total, no repeats.
- start pulsed again mid-frame, plus wr_en to addr 10 mid-frame -> both ignored; word 10 keeps its old value; a second frame started after frame_done streams normally.
- rst asserted at word 6 -> next cycle all outputs 0 and no frame_done; after a new start, stream restarts at word 0 with buffer contents intact.
- wr_addr=12 (out of range) -> no buffer change; with COORD_EN defined, row_out/col_out read (0,0)…(2,3) aligned with pixel_valid.
